// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: Game Boy PPU dot/line sequencer driving the renderer strobe,
// LY/STAT/LYC status, VBlank/STAT interrupts and CPU VRAM/OAM access gating.
module lcd_timing_ctrl #(
   parameter int DOTS_PER_LINE = 456,
   parameter int OAM_DOTS      = 80,
   parameter int DRAW_DOTS     = 172,
   parameter int VISIBLE_LINES = 144,
   parameter int TOTAL_LINES   = 154
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       dot_en_i,
   input  logic       lcd_on_i,
   input  logic [7:0] lyc_i,
   input  logic [3:0] stat_ie_i,
   output logic [7:0] ly_o,
   output logic [8:0] dot_o,
   output logic [1:0] mode_o,
   output logic       lyc_match_o,
   output logic       drawline_o,
   output logic       frame_done_o,
   output logic       vblank_irq_o,
   output logic       stat_irq_o,
   output logic       cpu_vram_ok_o,
   output logic       cpu_oam_ok_o
);
   // Low two state bits are the STAT mode; OFF reads back as mode 0.
   localparam logic [2:0] ST_HBLANK = 3'b000;
   localparam logic [2:0] ST_VBLANK = 3'b001;
   localparam logic [2:0] ST_OAM    = 3'b010;
   localparam logic [2:0] ST_DRAW   = 3'b011;
   localparam logic [2:0] ST_OFF    = 3'b100;
   localparam logic [8:0] DOT_LAST   = 9'(DOTS_PER_LINE - 1);
   localparam logic [8:0] DRAW_START = 9'(OAM_DOTS);
   localparam logic [8:0] DRAW_END   = 9'(OAM_DOTS + DRAW_DOTS);
   localparam logic [7:0] LY_VBL     = 8'(VISIBLE_LINES);
   localparam logic [7:0] LY_LAST    = 8'(TOTAL_LINES - 1);

   logic [2:0] state_q, state_d;
   logic [8:0] dot_q, dot_d;
   logic [7:0] ly_q, ly_d;
   logic       line_end;
   logic       drawline_q, drawline_d;
   logic       frame_q, frame_d;
   logic       lyc_match_q, lyc_match_d;
   logic       stat_line_q, stat_line_d;
   logic       stat_irq_q, stat_irq_d;
   logic       vram_ok_q, vram_ok_d;
   logic       oam_ok_q, oam_ok_d;

   assign line_end = dot_q == DOT_LAST;

   always_comb begin
      state_d = state_q;
      dot_d   = dot_q;
      ly_d    = ly_q;
      if (!lcd_on_i) begin
         state_d = ST_OFF;
         dot_d   = '0;
         ly_d    = '0;
      end else if (state_q == ST_OFF) state_d = ST_OAM;
      else if (dot_en_i) begin
         dot_d = line_end ? '0 : dot_q + 9'd1;
         ly_d  = !line_end ? ly_q : (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
         if (line_end) state_d = (ly_d < LY_VBL) ? ST_OAM : ST_VBLANK;
         else if (state_q == ST_OAM && dot_d == DRAW_START) state_d = ST_DRAW;
         else if (state_q == ST_DRAW && dot_d == DRAW_END) state_d = ST_HBLANK;
      end
   end

   // Gating with lcd_on_i keeps status and interrupts quiet from the first OFF cycle.
   assign drawline_d  = state_q == ST_OAM && state_d == ST_DRAW;
   assign frame_d     = state_q != ST_VBLANK && state_d == ST_VBLANK;
   assign lyc_match_d = lcd_on_i && ly_q == lyc_i;
   assign stat_line_d = lcd_on_i && state_q != ST_OFF &&
                        ((stat_ie_i[0] && state_q[1:0] == 2'd0) ||
                         (stat_ie_i[1] && state_q[1:0] == 2'd1) ||
                         (stat_ie_i[2] && state_q[1:0] == 2'd2) ||
                         (stat_ie_i[3] && lyc_match_q));
   assign stat_irq_d  = stat_line_d && !stat_line_q;
   assign vram_ok_d   = state_d != ST_DRAW;
   assign oam_ok_d    = state_d != ST_DRAW && state_d != ST_OAM;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_OFF;
         dot_q       <= '0;
         ly_q        <= '0;
         drawline_q  <= 1'b0;
         frame_q     <= 1'b0;
         lyc_match_q <= 1'b0;
         stat_line_q <= 1'b0;
         stat_irq_q  <= 1'b0;
         vram_ok_q   <= 1'b1;
         oam_ok_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         dot_q       <= dot_d;
         ly_q        <= ly_d;
         drawline_q  <= drawline_d;
         frame_q     <= frame_d;
         lyc_match_q <= lyc_match_d;
         stat_line_q <= stat_line_d;
         stat_irq_q  <= stat_irq_d;
         vram_ok_q   <= vram_ok_d;
         oam_ok_q    <= oam_ok_d;
      end
   end

   assign ly_o          = ly_q;
   assign dot_o         = dot_q;
   assign mode_o        = state_q[1:0];
   assign lyc_match_o   = lyc_match_q;
   assign drawline_o    = drawline_q;
   assign frame_done_o  = frame_q;
   assign vblank_irq_o  = frame_q;
   assign stat_irq_o    = stat_irq_q;
   assign cpu_vram_ok_o = vram_ok_q;
   assign cpu_oam_ok_o  = oam_ok_q;
endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb_lcd_timing_ctrl: directed bench for the PPU timing controller with a
// small dot/line model for the full-frame run.
module tb_lcd_timing_ctrl;
   logic       clk = 1'b0;
   logic       reset, dot_en, lcd_on;
   logic [7:0] lyc;
   logic [3:0] stat_ie;
   logic [7:0] ly;
   logic [8:0] dot;
   logic [1:0] mode;
   logic       lyc_match, drawline, frame_done, vblank_irq, stat_irq, cpu_vram_ok, cpu_oam_ok;
   int         errors = 0;
   int         checks = 0;

   lcd_timing_ctrl dut (
      .clk_i(clk), .reset_i(reset), .dot_en_i(dot_en), .lcd_on_i(lcd_on),
      .lyc_i(lyc), .stat_ie_i(stat_ie), .ly_o(ly), .dot_o(dot), .mode_o(mode),
      .lyc_match_o(lyc_match), .drawline_o(drawline), .frame_done_o(frame_done),
      .vblank_irq_o(vblank_irq), .stat_irq_o(stat_irq),
      .cpu_vram_ok_o(cpu_vram_ok), .cpu_oam_ok_o(cpu_oam_ok)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // {ly,dot,mode,lyc_match,drawline,frame_done,vblank_irq,stat_irq,vram_ok,oam_ok}
   function automatic logic [25:0] all_outs();
      return {ly, dot, mode, lyc_match, drawline, frame_done, vblank_irq, stat_irq, cpu_vram_ok, cpu_oam_ok};
   endfunction

   task automatic test_reset;
      reset = 1'b1; lcd_on = 1'b1; dot_en = 1'b1; lyc = 8'd0; stat_ie = 4'hf;
      step; step;
      checks++;
      if (all_outs() !== 26'h3) begin
         errors++; $display("FAIL reset_values: got %h want %h", all_outs(), 26'h3);
      end
   endtask

   task automatic test_slow_dot;
      logic [8:0] ed;
      logic [7:0] el;
      logic [1:0] em;
      reset = 1'b1; lcd_on = 1'b1; dot_en = 1'b0; lyc = 8'hff; stat_ie = 4'h0;
      step;
      reset = 1'b0;
      step;
      checks++;
      if ({ly, dot, mode} !== {8'd0, 9'd0, 2'd2}) begin
         errors++; $display("FAIL slow_enable: got ly=%0d dot=%0d mode=%0d want 0 0 2", ly, dot, mode);
      end
      for (int k = 1; k <= 456; k++) begin
         ed = 9'(k % 456);
         el = 8'(k / 456);
         em = (ed < 80) ? 2'd2 : (ed < 252) ? 2'd3 : 2'd0;
         dot_en = 1'b1;
         step;
         dot_en = 1'b0;
         checks++;
         if ({ly, dot, mode, drawline} !== {el, ed, em, k == 80}) begin
            errors++;
            $display("FAIL slow_tick %0d: got ly=%0d dot=%0d mode=%0d dl=%b want %0d %0d %0d %b",
                     k, ly, dot, mode, drawline, el, ed, em, k == 80);
         end
         for (int j = 0; j < 3; j++) begin
            step;
            checks++;
            if ({ly, dot, mode, drawline} !== {el, ed, em, 1'b0}) begin
               errors++;
               $display("FAIL slow_gap %0d.%0d: got ly=%0d dot=%0d mode=%0d dl=%b want %0d %0d %0d 0",
                        k, j, ly, dot, mode, drawline, el, ed, em);
            end
         end
      end
   endtask

   task automatic test_frame;
      int ed = 0, el = 0, ticks = 0;
      int n_draw = 0, n_frame = 0, n_lyc = 0, n_irq1 = 0, n_irq2 = 0, max_ly = 0;
      int irq1_ly = -1, irq2_ly = -1, irq2_mode = -1;
      bit phase2 = 0, done = 0;
      logic [1:0] em;
      reset = 1'b1; lcd_on = 1'b1; dot_en = 1'b1; lyc = 8'd5; stat_ie = 4'b1000;
      step;
      reset = 1'b0;
      step;
      for (int c = 0; c < 70400 && !done; c++) begin
         step;
         ticks++;
         ed++;
         if (ed == 456) begin
            ed = 0;
            el = (el == 153) ? 0 : el + 1;
         end
         em = (el >= 144) ? 2'd1 : (ed < 80) ? 2'd2 : (ed < 252) ? 2'd3 : 2'd0;
         checks++;
         if ({ly, dot, mode, drawline, frame_done, vblank_irq, cpu_vram_ok, cpu_oam_ok} !==
             {8'(el), 9'(ed), em, el < 144 && ed == 80, el == 144 && ed == 0, el == 144 && ed == 0,
              em != 2'd3, em < 2'd2}) begin
            errors++;
            $display("FAIL frame_model ly=%0d dot=%0d: got mode=%0d dl=%b fd=%b vb=%b vram=%b oam=%b want ly=%0d dot=%0d mode=%0d",
                     ly, dot, mode, drawline, frame_done, vblank_irq, cpu_vram_ok, cpu_oam_ok, el, ed, em);
         end
         n_draw += int'(drawline);
         n_frame += int'(frame_done);
         n_lyc += int'(lyc_match);
         if (int'(ly) > max_ly) max_ly = int'(ly);
         if (stat_irq && !phase2) begin n_irq1++; irq1_ly = int'(ly); end
         if (stat_irq && phase2) begin n_irq2++; irq2_ly = int'(ly); irq2_mode = int'(mode); end
         if (el == 143 && ed == 0 && !phase2) begin
            phase2 = 1;
            stat_ie = 4'b0011;
         end
         if (ly === 8'd0 && dot === 9'd0) done = 1;
      end
      checks++;
      if (ticks != 70224) begin errors++; $display("FAIL frame_ticks: got %0d want 70224", ticks); end
      checks++;
      if (n_draw != 144) begin errors++; $display("FAIL frame_drawlines: got %0d want 144", n_draw); end
      checks++;
      if (n_frame != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", n_frame); end
      checks++;
      if (max_ly != 153) begin errors++; $display("FAIL frame_max_ly: got %0d want 153", max_ly); end
      checks++;
      if (mode !== 2'd2) begin errors++; $display("FAIL frame_wrap_mode: got %0d want 2", mode); end
      checks++;
      if (n_lyc != 456) begin errors++; $display("FAIL lyc_match_cycles: got %0d want 456", n_lyc); end
      checks++;
      if (n_irq1 != 1 || irq1_ly != 5) begin
         errors++; $display("FAIL lyc_stat_irq: got count=%0d ly=%0d want 1 at ly 5", n_irq1, irq1_ly);
      end
      checks++;
      if (n_irq2 != 1 || irq2_ly != 143 || irq2_mode != 0) begin
         errors++;
         $display("FAIL stat_blocking: got count=%0d ly=%0d mode=%0d want 1 at ly 143 mode 0",
                  n_irq2, irq2_ly, irq2_mode);
      end
   endtask

   task automatic test_lcd_off;
      bit found = 0;
      int n_dl = 0;
      lyc = 8'd40; stat_ie = 4'b1000; dot_en = 1'b1; lcd_on = 1'b1;
      for (int c = 0; c < 20000 && !found; c++) begin
         step;
         if (ly === 8'd40 && dot === 9'd100) found = 1;
      end
      checks++;
      if (!found || {mode, lyc_match, cpu_oam_ok, cpu_vram_ok} !== {2'd3, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL off_precondition: got found=%0d mode=%0d lm=%b oam=%b vram=%b want 1 3 1 0 0",
                  found, mode, lyc_match, cpu_oam_ok, cpu_vram_ok);
      end
      lcd_on = 1'b0;
      step;
      checks++;
      if ({ly, dot, mode, drawline, stat_irq, lyc_match, cpu_vram_ok, cpu_oam_ok} !==
          {8'd0, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL off_entry: got ly=%0d dot=%0d mode=%0d dl=%b si=%b lm=%b vram=%b oam=%b want 0 0 0 0 0 0 1 1",
                  ly, dot, mode, drawline, stat_irq, lyc_match, cpu_vram_ok, cpu_oam_ok);
      end
      for (int c = 0; c < 3; c++) begin
         step;
         n_dl += int'(drawline) + int'(stat_irq) + int'(dot != 9'd0);
      end
      checks++;
      if (n_dl != 0) begin errors++; $display("FAIL off_hold: got %0d activity events want 0", n_dl); end
      lcd_on = 1'b1; dot_en = 1'b0;
      step;
      checks++;
      if ({ly, dot, mode, cpu_oam_ok, cpu_vram_ok} !== {8'd0, 9'd0, 2'd2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reenable: got ly=%0d dot=%0d mode=%0d oam=%b vram=%b want 0 0 2 0 1",
                  ly, dot, mode, cpu_oam_ok, cpu_vram_ok);
      end
      step;
      checks++;
      if (dot !== 9'd0) begin errors++; $display("FAIL freeze_no_tick: got dot=%0d want 0", dot); end
      dot_en = 1'b1;
      step;
      checks++;
      if (dot !== 9'd1) begin errors++; $display("FAIL resume_tick: got dot=%0d want 1", dot); end
   endtask

   task automatic test_reset_mid_draw;
      lyc = 8'd0; stat_ie = 4'h0; dot_en = 1'b1; lcd_on = 1'b1;
      for (int c = 0; c < 99; c++) step;
      checks++;
      if ({dot, mode, lyc_match} !== {9'd100, 2'd3, 1'b1}) begin
         errors++; $display("FAIL mid_draw_pre: got dot=%0d mode=%0d lm=%b want 100 3 1", dot, mode, lyc_match);
      end
      reset = 1'b1;
      step;
      checks++;
      if (all_outs() !== 26'h3) begin
         errors++; $display("FAIL mid_draw_reset: got %h want %h", all_outs(), 26'h3);
      end
      reset = 1'b0;
      step;
      checks++;
      if ({ly, dot, mode} !== {8'd0, 9'd0, 2'd2}) begin
         errors++; $display("FAIL post_reset_enable: got ly=%0d dot=%0d mode=%0d want 0 0 2", ly, dot, mode);
      end
   endtask

   initial begin
      test_reset;
      test_slow_dot;
      test_frame;
      test_lcd_off;
      test_reset_mid_draw;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lcd_timing_ctrl.md
Name: lcd_timing_ctrl

Overview:
- Sequences the background line renderer and LCD registers through Game Boy PPU timing.
- Counts dots and lines and drives the per-line `drawline` strobe consumed by the renderer.
- Publishes LY, the STAT mode and the LYC match; raises VBlank and STAT interrupt requests.
- Gates CPU access to VRAM/OAM by mode, acting as the scheduler between the CPU bus and the renderer.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline
- OAM_DOTS, 80, length of mode 2
- DRAW_DOTS, 172, length of mode 3 (fixed; no sprite penalty)
- VISIBLE_LINES, 144, lines with modes 2/3/0
- TOTAL_LINES, 154, lines per frame including VBlank

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- dot_en  in  1  one-cycle dot tick; all timing advances only on cycles with dot_en=1
- lcd_on  in  1  LCDC bit 7
- lyc  in  8  LY compare register value
- stat_ie  in  4  STAT interrupt enables: [0]=HBlank, [1]=VBlank, [2]=OAM, [3]=LYC
- ly  out  8  current line, 0..TOTAL_LINES-1
- dot  out  9  dot within line, 0..DOTS_PER_LINE-1
- mode  out  2  0=HBlank, 1=VBlank, 2=OAM scan, 3=draw
- lyc_match  out  1  ly==lyc
- drawline  out  1  one-cycle pulse at entry to mode 3
- frame_done  out  1  one-cycle pulse at entry to VBlank (ly becomes VISIBLE_LINES)
- vblank_irq  out  1  one-cycle request pulse, same cycle as frame_done
- stat_irq  out  1  one-cycle request pulse on the rising edge of the STAT line
- cpu_vram_ok  out  1  CPU may access VRAM
- cpu_oam_ok  out  1  CPU may access OAM

Behaviour:
- All outputs are registered. Reset (sync, active-high) has priority over everything:
  - ly=0, dot=0, mode=0, state=OFF
  - all pulses 0, lyc_match=0, internal stat_line=0
  - cpu_vram_ok=1, cpu_oam_ok=1
- States:
  - OFF: mode=0, ly=0, dot=0, both access enables 1, no pulses.
  - OAM (mode 2): dot 0..OAM_DOTS-1.
  - DRAW (mode 3): dot OAM_DOTS..OAM_DOTS+DRAW_DOTS-1.
  - HBLANK (mode 0): remaining dots of a visible line.
  - VBLANK (mode 1): lines VISIBLE_LINES..TOTAL_LINES-1.
- Transitions, evaluated only when dot_en=1. The new state, dot and ly are visible the cycle after the tick.
  - dot increments by 1. At DOTS_PER_LINE-1 it wraps to 0 and ly increments.
  - At ly=TOTAL_LINES-1 with dot wrapping, ly wraps to 0 and the state goes to OAM.
  - OAM→DRAW when dot reaches OAM_DOTS; drawline pulses for exactly one clk.
  - DRAW→HBLANK when dot reaches OAM_DOTS+DRAW_DOTS.
  - HBLANK→OAM at the line wrap while the new ly < VISIBLE_LINES.
  - HBLANK→VBLANK when the new ly == VISIBLE_LINES; frame_done and vblank_irq pulse one clk.
- LCD enable:
  - lcd_on=0 in any state: the next clk enters OFF, regardless of dot_en. Mid-line or mid-draw abort is legal; no drawline is issued.
  - On the first clk with lcd_on=1 while in OFF: enter OAM with ly=0, dot=0. Counting then resumes on dot_en.
  - drawline is never asserted while in OFF.
- Access gating:
  - cpu_oam_ok=0 in modes 2 and 3.
  - cpu_vram_ok=0 in mode 3 only.
  - Both are 1 otherwise, including OFF.
- LYC: lyc_match is recomputed every clk from the registered ly and the lyc input (one clk latency from either changing). It is 0 in OFF.
- STAT interrupt:
  - stat_line = (ie[0]&mode==0) | (ie[1]&mode==1) | (ie[2]&mode==2) | (ie[3]&lyc_match), evaluated on registered values.
  - stat_irq pulses only on a 0→1 transition of stat_line. Overlapping sources that keep the line high generate no second pulse (STAT blocking).
  - stat_line is forced to 0 in OFF.
- Pulses never stretch: each is held high for one clk regardless of dot_en rate.
- dot_en held high every clk is legal (fastest rate). Gaps between dot_en ticks freeze all counters and state.

Test Plan:
- Reset, lcd_on=1, dot_en=1 constant → mode goes 2 at dot 0, 3 at dot 80 with drawline for one clk, 0 at dot 252; ly=1 at clk 456.
- Run a full frame → exactly 144 drawline pulses; frame_done/vblank_irq once when ly becomes 144; ly reaches 153 then wraps to 0 in mode 2; total 70224 ticks per frame.
- lyc=5, stat_ie=4'b1000 → one stat_irq when ly becomes 5 (lyc_match high lines 5 only); none else in frame.
- stat_ie=4'b0011 across line 143→144 (HBlank then VBlank) → only one stat_irq at the first HBlank entry of line 143, no pulse at VBlank entry because the line stays high.
- Deassert lcd_on at ly=40, dot=100 (mode 3) → next clk: mode=0, ly=0, cpu_vram_ok=1, cpu_oam_ok=1, no drawline. Re-enable → mode 2, ly=0, dot=0.
- dot_en every 4th clk → all transitions occur at the same dot values as the constant case; each pulse lasts 1 clk. Assert reset mid-DRAW → next clk all outputs at reset values.
